// File: rtl/if_id_tracker.sv
// ---------------------------------------------------------------------------
// if_id_tracker
//
// Passive trace monitor for the IF and ID pipeline stages. It follows the
// instruction-memory handshake and the IF/ID status lines and, for every
// traced instruction, produces one record: fetch address, instruction word
// and the cycle timestamps of IF entry/exit and ID entry/exit. Records are
// emitted on a one-cycle trace_data_ready pulse. The fields stay stable
// until the next record is emitted.
//
// Ports
//   clk               clock, all state on the rising edge
//   rst               asynchronous, active-low reset
//   if_busy           IF status (observed only, does not affect records)
//   if_ready          IF hands its instruction to ID this cycle
//   instr_req/addr    instruction-memory request and address
//   instr_grant       request accepted
//   instr_rvalid/rdata read data valid and instruction word
//   is_decoding       ID stage is decoding an instruction
//   trace_data_ready  one-cycle pulse, record fields are valid
//   trace_addr/instr  fetch address and instruction word
//   trace_if_start/end, trace_id_start/end   cycle timestamps
//   trace_overflow    sticky, set when a record was lost
// ---------------------------------------------------------------------------
module if_id_tracker #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_busy,
    input  logic                  if_ready,
    input  logic                  instr_req,
    input  logic [ADDR_WIDTH-1:0] instr_addr,
    input  logic                  instr_grant,
    input  logic                  instr_rvalid,
    input  logic [DATA_WIDTH-1:0] instr_rdata,
    input  logic                  is_decoding,
    output logic                  trace_data_ready,
    output logic [ADDR_WIDTH-1:0] trace_addr,
    output logic [DATA_WIDTH-1:0] trace_instr,
    output logic [31:0]           trace_if_start,
    output logic [31:0]           trace_if_end,
    output logic [31:0]           trace_id_start,
    output logic [31:0]           trace_id_end,
    output logic                  trace_overflow
);

    localparam logic [1:0] IF_IDLE        = 2'd0;
    localparam logic [1:0] IF_WAIT_GNT    = 2'd1;
    localparam logic [1:0] IF_WAIT_RVALID = 2'd2;
    localparam logic [1:0] IF_WAIT_READY  = 2'd3;

    localparam logic [1:0] ID_IDLE   = 2'd0;
    localparam logic [1:0] ID_WAIT   = 2'd1;
    localparam logic [1:0] ID_DECODE = 2'd2;

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] instr;
        logic [31:0]           if_start;
        logic [31:0]           if_end;
    } rec_t;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // if_busy is pure status; records are built from the handshake alone.
    logic unused_if_busy;
    assign unused_if_busy = if_busy;

    logic [31:0]           cnt_q;
    logic [1:0]            if_state_q, if_state_d;
    logic [31:0]           if_start_q, if_start_d;
    logic [ADDR_WIDTH-1:0] if_addr_q, if_addr_d;
    logic [DATA_WIDTH-1:0] if_instr_q, if_instr_d;
    logic                  push, stray_grant;
    rec_t                  push_rec;

    rec_t                  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  full, push_ok, drop;

    logic [1:0]            id_state_q, id_state_d;
    logic [31:0]           id_start_q, id_start_d;
    logic                  dec_prev_q;
    logic                  id_load, id_emit;
    rec_t                  work_q;

    logic                  rdy_q, ovf_q;
    logic [ADDR_WIDTH-1:0] out_addr_q;
    logic [DATA_WIDTH-1:0] out_instr_q;
    logic [31:0]           out_ifs_q, out_ife_q, out_ids_q, out_ide_q;

    // ---------------- IF side: one outstanding fetch ----------------
    always_comb begin
        if_state_d      = if_state_q;
        if_start_d      = if_start_q;
        if_addr_d       = if_addr_q;
        if_instr_d      = if_instr_q;
        push            = 1'b0;
        stray_grant     = 1'b0;
        push_rec.addr     = if_addr_q;
        push_rec.instr    = if_instr_q;
        push_rec.if_start = if_start_q;
        push_rec.if_end   = cnt_q;
        case (if_state_q)
            IF_IDLE: begin
                if (instr_req) begin
                    if_start_d = cnt_q;
                    if (instr_grant) begin
                        if_addr_d  = instr_addr;
                        if_state_d = IF_WAIT_RVALID;
                    end else begin
                        if_state_d = IF_WAIT_GNT;
                    end
                end
            end
            IF_WAIT_GNT: begin
                if (instr_grant) begin
                    if_addr_d  = instr_addr;
                    if_state_d = IF_WAIT_RVALID;
                end
            end
            IF_WAIT_RVALID: begin
                if (instr_rvalid) begin
                    if_instr_d = instr_rdata;
                    if (if_ready) begin
                        push_rec.instr = instr_rdata;
                        push           = 1'b1;
                    end else begin
                        if_state_d = IF_WAIT_READY;
                    end
                end
                // A second grant while a fetch is still open cannot be traced.
                stray_grant = instr_grant && !push;
            end
            IF_WAIT_READY: begin
                if (if_ready) begin
                    push = 1'b1;
                end
                stray_grant = instr_grant && !push;
            end
            default: if_state_d = IF_IDLE;
        endcase
        // On completion a new request granted in the same cycle starts at once.
        if (push) begin
            if (instr_req && instr_grant) begin
                if_start_d = cnt_q;
                if_addr_d  = instr_addr;
                if_state_d = IF_WAIT_RVALID;
            end else begin
                if_state_d = IF_IDLE;
            end
        end
    end

    // ---------------- Record buffer ----------------
    // The head slot stays occupied while ID works on it and is released only
    // when its record is emitted, so at most FIFO_DEPTH records are in flight.
    assign full    = (count_q == CNT_W'(FIFO_DEPTH));
    assign push_ok = push && (!full || id_emit);
    assign drop    = push && !push_ok;

    always_comb begin
        wr_ptr_d = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = id_emit ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push_ok) - CNT_W'(id_emit);
    end

    // Storage and registered read of the head into the working record.
    // Load and emit never coincide, so the read slot is never being written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= push_rec;
        end
        if (id_load) begin
            work_q <= mem[rd_ptr_q];
        end
    end

    // ---------------- ID side ----------------
    always_comb begin
        id_state_d = id_state_q;
        id_start_d = id_start_q;
        id_load    = 1'b0;
        id_emit    = 1'b0;
        case (id_state_q)
            ID_IDLE: begin
                if (count_q != '0) begin
                    id_load    = 1'b1;
                    id_state_d = ID_WAIT;
                end
            end
            ID_WAIT: begin
                // Only a fresh rising edge starts decode, so a run already in
                // progress when the record was loaded is never claimed.
                if (is_decoding && !dec_prev_q) begin
                    id_start_d = cnt_q;
                    id_state_d = ID_DECODE;
                end
            end
            ID_DECODE: begin
                if (!is_decoding) begin
                    id_emit    = 1'b1;
                    id_state_d = ID_IDLE;
                end
            end
            default: id_state_d = ID_IDLE;
        endcase
    end

    // ---------------- State registers ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= '0;
            if_state_q  <= IF_IDLE;
            if_start_q  <= '0;
            if_addr_q   <= '0;
            if_instr_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            id_state_q  <= ID_IDLE;
            id_start_q  <= '0;
            dec_prev_q  <= 1'b0;
            rdy_q       <= 1'b0;
            ovf_q       <= 1'b0;
            out_addr_q  <= '0;
            out_instr_q <= '0;
            out_ifs_q   <= '0;
            out_ife_q   <= '0;
            out_ids_q   <= '0;
            out_ide_q   <= '0;
        end else begin
            cnt_q      <= cnt_q + 32'd1;
            if_state_q <= if_state_d;
            if_start_q <= if_start_d;
            if_addr_q  <= if_addr_d;
            if_instr_q <= if_instr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            id_state_q <= id_state_d;
            id_start_q <= id_start_d;
            dec_prev_q <= is_decoding;
            rdy_q      <= id_emit;
            ovf_q      <= ovf_q | drop | stray_grant;
            if (id_emit) begin
                out_addr_q  <= work_q.addr;
                out_instr_q <= work_q.instr;
                out_ifs_q   <= work_q.if_start;
                out_ife_q   <= work_q.if_end;
                out_ids_q   <= id_start_q;
                // The fall is seen one cycle late; the last decode cycle is cnt-1.
                out_ide_q   <= cnt_q - 32'd1;
            end
        end
    end

    assign trace_data_ready = rdy_q;
    assign trace_addr       = out_addr_q;
    assign trace_instr      = out_instr_q;
    assign trace_if_start   = out_ifs_q;
    assign trace_if_end     = out_ife_q;
    assign trace_id_start   = out_ids_q;
    assign trace_id_end     = out_ide_q;
    assign trace_overflow   = ovf_q;

endmodule

// File: tb/tb_if_id_tracker.sv
// ---------------------------------------------------------------------------
// tb_if_id_tracker
//
// Directed bench for if_id_tracker. A transaction-level model follows the
// input handshake, keeps the in-flight records in a queue and predicts the
// registered outputs; a single negedge process compares DUT and model every
// cycle. Literal record values per scenario pin both the model and the DUT.
// ---------------------------------------------------------------------------
module tb_if_id_tracker;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_busy = 1'b0, if_ready = 1'b0, instr_req = 1'b0, instr_grant = 1'b0;
    logic        instr_rvalid = 1'b0, is_decoding = 1'b0;
    logic [31:0] instr_addr = '0, instr_rdata = '0;
    logic        trace_data_ready, trace_overflow;
    logic [31:0] trace_addr, trace_instr, trace_if_start, trace_if_end, trace_id_start, trace_id_end;

    if_id_tracker #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .if_busy(if_busy), .if_ready(if_ready),
        .instr_req(instr_req), .instr_addr(instr_addr), .instr_grant(instr_grant),
        .instr_rvalid(instr_rvalid), .instr_rdata(instr_rdata), .is_decoding(is_decoding),
        .trace_data_ready(trace_data_ready), .trace_addr(trace_addr), .trace_instr(trace_instr),
        .trace_if_start(trace_if_start), .trace_if_end(trace_if_end),
        .trace_id_start(trace_id_start), .trace_id_end(trace_id_end),
        .trace_overflow(trace_overflow)
    );

    always #5 clk = ~clk;

    // Cycle number as seen by the design: 0 in the first cycle after reset.
    logic [31:0] cyc;
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= '0;
        else      cyc <= cyc + 32'd1;
    end

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {31'b0, act}, {31'b0, exp});
    endtask

    typedef struct {
        logic [31:0] addr, instr, ifs, ife, ids, ide, at;
    } trec_t;

    // ---------------- Model state ----------------
    trec_t       pend_q[$];     // completed fetches not yet emitted (head = one in ID)
    trec_t       mdl_log[$];    // records the model says must be emitted
    trec_t       dut_log[$];    // records the DUT actually emitted
    trec_t       e_rec, r;
    logic        e_rdy, e_ovf, n_rdy, lost, fin, dec_prev;
    int          m_dec;         // 0 no record held, 1 armed for next rising edge, 2 in a run
    logic [31:0] m_ids;
    logic        f_act, f_gnt, f_have;
    logic [31:0] f_start, f_addr, f_data;
    logic [191:0] got_v, want_v;

    always @(negedge clk) begin
        if (!rst) begin
            pend_q.delete();
            e_rec = '{default: '0};
            e_rdy = 1'b0; e_ovf = 1'b0; dec_prev = 1'b0; m_dec = 0; m_ids = '0;
            f_act = 1'b0; f_gnt = 1'b0; f_have = 1'b0;
            f_start = '0; f_addr = '0; f_data = '0;
        end else begin
            // Compare current outputs with what the model predicted.
            chk1("ready", trace_data_ready, e_rdy);
            chk1("overflow", trace_overflow, e_ovf);
            got_v  = {trace_addr, trace_instr, trace_if_start, trace_if_end, trace_id_start, trace_id_end};
            want_v = {e_rec.addr, e_rec.instr, e_rec.ifs, e_rec.ife, e_rec.ids, e_rec.ide};
            n_cmp++;
            if (got_v !== want_v) begin
                n_fail++;
                $display("FAIL fields: got %h want %h (cycle %0d)", got_v, want_v, cyc);
            end
            if (trace_data_ready) begin
                $display("rec @%0d addr=%h instr=%h if=%0d/%0d id=%0d/%0d", cyc, trace_addr,
                         trace_instr, trace_if_start, trace_if_end, trace_id_start, trace_id_end);
                dut_log.push_back('{trace_addr, trace_instr, trace_if_start, trace_if_end,
                                    trace_id_start, trace_id_end, cyc});
            end

            // Decode side: a record is claimed by the first rising edge of
            // is_decoding after it is loaded, and emitted after the run ends.
            n_rdy = 1'b0;
            lost  = 1'b0;
            if (m_dec == 2 && !is_decoding) begin
                r = pend_q.pop_front();
                r.ids = m_ids; r.ide = cyc - 32'd1; r.at = cyc + 32'd1;
                e_rec = r; n_rdy = 1'b1;
                mdl_log.push_back(r);
                m_dec = 0;
            end else if (m_dec == 1 && is_decoding && !dec_prev) begin
                m_ids = cyc; m_dec = 2;
            end else if (m_dec == 0 && pend_q.size() > 0) begin
                m_dec = 1;
            end
            dec_prev = is_decoding;

            // Fetch side: one fetch open at a time.
            fin = 1'b0;
            if (f_act && f_gnt) begin
                if (!f_have && instr_rvalid) begin f_data = instr_rdata; f_have = 1'b1; end
                if (f_have && if_ready) fin = 1'b1;
                else if (instr_grant)   lost = 1'b1;
            end
            if (fin) begin
                r = '{f_addr, f_data, f_start, cyc, 32'd0, 32'd0, 32'd0};
                if (pend_q.size() < DEPTH) pend_q.push_back(r);
                else                       lost = 1'b1;
                f_act = 1'b0;
                if (instr_req && instr_grant) begin
                    f_act = 1'b1; f_gnt = 1'b1; f_have = 1'b0; f_start = cyc; f_addr = instr_addr;
                end
            end else if (!f_act) begin
                if (instr_req) begin
                    f_act = 1'b1; f_gnt = instr_grant; f_have = 1'b0; f_start = cyc; f_addr = instr_addr;
                end
            end else if (!f_gnt && instr_grant) begin
                f_gnt = 1'b1; f_addr = instr_addr;
            end
            e_rdy = n_rdy;
            if (lost) e_ovf = 1'b1;
        end
    end

    // ---------------- Stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int n);
        int guard = 0;
        while (cyc != 32'(n) && guard < 200) begin
            tick();
            guard++;
        end
        chk("goto cycle", cyc, 32'(n));
    endtask

    // Move to cycle n with the handshake lines idle.
    task automatic at(input int n);
        goto(n);
        instr_req = 1'b0; instr_grant = 1'b0; instr_rvalid = 1'b0; if_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        instr_req = 1'b0; instr_grant = 1'b0; instr_rvalid = 1'b0; if_ready = 1'b0;
        is_decoding = 1'b0; if_busy = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        mdl_log.delete();
        dut_log.delete();
    endtask

    task automatic check_count(input string name, input int n);
        chk({name, " dut count"}, 32'(dut_log.size()), 32'(n));
        chk({name, " model count"}, 32'(mdl_log.size()), 32'(n));
    endtask

    task automatic check_rec(input string name, input int idx, input logic [31:0] a,
                             input logic [31:0] i, input logic [31:0] s, input logic [31:0] e,
                             input logic [31:0] ds, input logic [31:0] de, input logic [31:0] t);
        if (idx >= dut_log.size() || idx >= mdl_log.size()) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: record %0d missing (dut %0d, model %0d)", name, idx,
                     dut_log.size(), mdl_log.size());
        end else begin
            chk({name, " addr"},     dut_log[idx].addr,  a);
            chk({name, " instr"},    dut_log[idx].instr, i);
            chk({name, " if_start"}, dut_log[idx].ifs,   s);
            chk({name, " if_end"},   dut_log[idx].ife,   e);
            chk({name, " id_start"}, dut_log[idx].ids,   ds);
            chk({name, " id_end"},   dut_log[idx].ide,   de);
            chk({name, " pulse"},    dut_log[idx].at,    t);
            chk({name, " model addr"},     mdl_log[idx].addr,  a);
            chk({name, " model if_start"}, mdl_log[idx].ifs,   s);
            chk({name, " model if_end"},   mdl_log[idx].ife,   e);
            chk({name, " model id_start"}, mdl_log[idx].ids,   ds);
            chk({name, " model id_end"},   mdl_log[idx].ide,   de);
            chk({name, " model pulse"},    mdl_log[idx].at,    t);
        end
    endtask

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        // Reset state
        do_reset();
        chk1("reset ready", trace_data_ready, 1'b0);
        chk1("reset overflow", trace_overflow, 1'b0);
        chk("reset addr", trace_addr, 32'h0);

        // Single fetch, timestamps counted from reset
        at(5);  instr_req = 1'b1; instr_grant = 1'b1; instr_addr = 32'h100; if_busy = 1'b1;
        at(6);
        at(7);  instr_rvalid = 1'b1; instr_rdata = 32'h13; if_ready = 1'b1;
        at(8);  if_busy = 1'b0;
        at(9);  is_decoding = 1'b1;
        at(11); is_decoding = 1'b0;
        at(14);
        check_count("single", 1);
        check_rec("single", 0, 32'h100, 32'h13, 32'd5, 32'd7, 32'd9, 32'd10, 32'd12);

        // Delayed grant and delayed if_ready
        do_reset();
        at(3);  instr_req = 1'b1; instr_addr = 32'h200; if_busy = 1'b1;
        at(4);  instr_req = 1'b1;
        at(5);  instr_req = 1'b1;
        at(6);  instr_req = 1'b1; instr_grant = 1'b1;
        at(7);
        at(8);  instr_rvalid = 1'b1; instr_rdata = 32'hA;
        at(9);
        at(10); if_ready = 1'b1;
        at(11); if_busy = 1'b0;
        at(12); is_decoding = 1'b1;
        at(14); is_decoding = 1'b0;
        at(17);
        check_count("delayed", 1);
        check_rec("delayed", 0, 32'h200, 32'hA, 32'd3, 32'd10, 32'd12, 32'd13, 32'd15);

        // Back-to-back fetches; second decode run is a single cycle
        do_reset();
        at(2);  instr_req = 1'b1; instr_grant = 1'b1; instr_addr = 32'h300;
        at(3);
        at(4);  instr_rvalid = 1'b1; if_ready = 1'b1; instr_rdata = 32'h11;
                instr_req = 1'b1; instr_grant = 1'b1; instr_addr = 32'h304;
        at(5);  instr_rvalid = 1'b1; if_ready = 1'b1; instr_rdata = 32'h22;
        at(6);
        at(7);  is_decoding = 1'b1;
        at(9);  is_decoding = 1'b0;
        at(12); is_decoding = 1'b1;
        at(13); is_decoding = 1'b0;
        at(16);
        check_count("b2b", 2);
        check_rec("b2b first", 0, 32'h300, 32'h11, 32'd2, 32'd4, 32'd7, 32'd8, 32'd10);
        check_rec("b2b second", 1, 32'h304, 32'h22, 32'd4, 32'd5, 32'd12, 32'd12, 32'd14);
        if (dut_log.size() == 2) chk("b2b chain", dut_log[1].ifs, dut_log[0].ife);
        chk1("b2b overflow", trace_overflow, 1'b0);

        // Overflow: five records while ID is idle, the fifth is lost
        do_reset();
        at(2);  instr_req = 1'b1; instr_grant = 1'b1; instr_addr = 32'h400;
        for (int k = 1; k <= 5; k++) begin
            at(k + 2);
            instr_rvalid = 1'b1; if_ready = 1'b1; instr_rdata = 32'h1000 + 32'(k);
            if (k < 5) begin
                instr_req = 1'b1; instr_grant = 1'b1; instr_addr = 32'h400 + 32'(4 * k);
            end
            if (k == 5) chk1("ovf before drop", trace_overflow, 1'b0);
        end
        at(8);
        chk1("ovf after drop", trace_overflow, 1'b1);
        for (int k = 0; k < 5; k++) begin
            at(12 + 4 * k); is_decoding = 1'b1;
            at(13 + 4 * k); is_decoding = 1'b0;
        end
        at(34);
        check_count("ovf", 4);
        for (int k = 0; k < 4; k++) begin
            check_rec("ovf rec", k, 32'h400 + 32'(4 * k), 32'h1001 + 32'(k), 32'(k + 2),
                      32'(k + 3), 32'(12 + 4 * k), 32'(12 + 4 * k), 32'(14 + 4 * k));
        end
        chk1("ovf sticky", trace_overflow, 1'b1);

        // is_decoding already high when the record is loaded: wait for next rise
        do_reset();
        at(1);  instr_req = 1'b1; instr_grant = 1'b1; instr_addr = 32'h700;
        at(2);
        at(3);  instr_rvalid = 1'b1; if_ready = 1'b1; instr_rdata = 32'h77;
        at(4);  is_decoding = 1'b1;
        at(6);  is_decoding = 1'b0;
        at(8);  is_decoding = 1'b1;
        at(9);  is_decoding = 1'b0;
        at(12);
        check_count("late rise", 1);
        check_rec("late rise", 0, 32'h700, 32'h77, 32'd1, 32'd3, 32'd8, 32'd8, 32'd10);

        // Reset in the middle of a fetch
        at(12); instr_req = 1'b1; instr_grant = 1'b1; instr_addr = 32'h500;
        at(13);
        #2;
        rst = 1'b0;
        #1;
        chk1("rst ready", trace_data_ready, 1'b0);
        chk1("rst overflow", trace_overflow, 1'b0);
        chk("rst addr", trace_addr, 32'h0);
        chk("rst instr", trace_instr, 32'h0);
        chk("rst if_start", trace_if_start, 32'h0);
        chk("rst if_end", trace_if_end, 32'h0);
        chk("rst id_start", trace_id_start, 32'h0);
        chk("rst id_end", trace_id_end, 32'h0);
        mdl_log.delete();
        dut_log.delete();
        tick();
        tick();
        rst = 1'b1;
        // Stale read data for the aborted fetch must be ignored.
        instr_rvalid = 1'b1; if_ready = 1'b1; instr_rdata = 32'hDEAD;
        at(1);  instr_req = 1'b1; instr_grant = 1'b1; instr_addr = 32'h600;
        at(2);  instr_rvalid = 1'b1; if_ready = 1'b1; instr_rdata = 32'h66;
        at(3);
        at(4);  is_decoding = 1'b1;
        at(5);  is_decoding = 1'b0;
        at(9);
        check_count("after reset", 1);
        check_rec("after reset", 0, 32'h600, 32'h66, 32'd1, 32'd2, 32'd4, 32'd4, 32'd6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
